// File: rtl/scale_pkg.sv
// Shared scale data-path types, used by the scale mux, the output FIFO and their benches.
package scale_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] data_t;

endpackage : scale_pkg

// File: rtl/scale_out_fifo_if.sv
// Handshake bundle between the scale mux, the output FIFO and the downstream consumer.
interface scale_out_fifo_if #(
   parameter int WIDTH = scale_pkg::DATA_W,
   parameter int DEPTH = 4
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             flush;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] count;

   // master: the environment around the FIFO (producer and consumer side)
   modport master (
      output flush, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, count
   );

   modport slave (
      input  flush, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, count
   );

endinterface : scale_out_fifo_if

// File: rtl/scale_out_fifo.sv
// First-word-fall-through FIFO decoupling the scale mux output from downstream back-pressure.
module scale_out_fifo
   import scale_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   scale_out_fifo_if.slave   bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push;
   logic             pop;

   // in_ready depends only on registered occupancy, never on out_ready
   assign bus.in_ready  = (count_q < FULL_CNT) & ~rst;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.count     = count_q;

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so natural overflow gives the modulo wrap
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; out_data is masked by out_valid, so stale entries are never seen.
   always_ff @(posedge clk) begin
      if (push && !bus.flush) begin
         mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

endmodule : scale_out_fifo
